// File: rtl/alu_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_arb_pkg
// Description : Shared types and constants for the ALU arbiter. This package
//               holds the arbiter state encoding and the ALU op codes that the
//               arbiter issues on alu_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_arb_pkg;

  // Arbiter sequencing: accept in IDLE, drive the ALU in ISSUE, hand the
  // registered result back in RESP.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  // ALU op codes understood by the execute-stage ALU.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b100;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational request picker for the ALU arbiter.
//               Default build: round-robin, the first asserted request at or
//               after i_rr_ptr wins, wrapping NUM_REQ-1 to 0.
//               With ALU_ARB_FIXED_PRIO_EN defined: fixed priority, lowest
//               index wins, and the i_rr_ptr port does not exist.
// Ports       : i_req         request vector (NUM_REQ)
//               i_rr_ptr      round-robin start index (default build only)
//               o_grant       one-hot grant, zero when no request
//               o_grant_idx   binary index of the granted request
//               o_grant_valid at least one request is asserted
// Macro       : ALU_ARB_FIXED_PRIO_EN
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
`ifndef ALU_ARB_FIXED_PRIO_EN
  input  logic [IDX_W-1:0]   i_rr_ptr,
`endif
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx,
  output logic               o_grant_valid
);

  logic [IDX_W-1:0] w_idx;
`ifndef ALU_ARB_FIXED_PRIO_EN
  int               w_pos;
`endif

  always_comb begin
    o_grant       = '0;
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    w_idx         = '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
    w_pos         = 0;
`endif
    // Scan candidates in priority order; the first asserted one wins.
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      w_idx = IDX_W'(k);
`else
      // Modulo by subtraction keeps non-power-of-two NUM_REQ correct.
      w_pos = int'(i_rr_ptr) + k;
      if (w_pos >= NUM_REQ) begin
        w_pos = w_pos - NUM_REQ;
      end
      w_idx = IDX_W'(w_pos);
`endif
      if (!o_grant_valid && i_req[w_idx]) begin
        o_grant_valid  = 1'b1;
        o_grant_idx    = w_idx;
        o_grant[w_idx] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one combinational execute-stage ALU between NUM_REQ
//               requesters. One op is accepted in IDLE, driven onto the ALU
//               for exactly one cycle in ISSUE, and its registered result/EQ
//               is returned in RESP until the granted requester takes it.
//               Accept in cycle N gives rsp_valid in cycle N+2.
// Ports       : clk, rst                  clock, synchronous active-high reset
//               req_valid/req_ready       per-requester request handshake
//               req_a/req_b/req_op        packed operands and op codes
//               rsp_valid/rsp_ready       per-requester response handshake
//               rsp_result/rsp_eq         shared response bus
//               alu_src_a/b, alu_ctrl     to the ALU (zero outside ISSUE)
//               alu_result, alu_eq        from the ALU
// Macro       : ALU_ARB_FIXED_PRIO_EN selects fixed lowest-index priority
//               instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*3-1:0] req_op,
  output logic [NUM_REQ-1:0]   rsp_valid,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output logic [WIDTH-1:0]     rsp_result,
  output logic                 rsp_eq,
  output logic [WIDTH-1:0]     alu_src_a,
  output logic [WIDTH-1:0]     alu_src_b,
  output logic [2:0]           alu_ctrl,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_eq
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_REQ - 1);

  state_e           state_q,     state_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [WIDTH-1:0] a_q,         a_d;
  logic [WIDTH-1:0] b_q,         b_d;
  logic [2:0]       op_q,        op_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic             eq_q,        eq_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] rr_ptr_q,    rr_ptr_d;
`endif

  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_grant_valid;
  logic               w_rsp_ack;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .i_req         (req_valid),
`ifndef ALU_ARB_FIXED_PRIO_EN
    .i_rr_ptr      (rr_ptr_q),
`endif
    .o_grant       (w_grant),
    .o_grant_idx   (w_grant_idx),
    .o_grant_valid (w_grant_valid)
  );

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    result_d    = result_q;
    eq_d        = eq_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    req_ready   = '0;
    rsp_valid   = '0;
    alu_src_a   = '0;
    alu_src_b   = '0;
    alu_ctrl    = ALU_ADD;
    w_rsp_ack   = 1'b0;

    case (state_q)
      IDLE: begin
        // The arbiter only grants asserted requests, so the grant vector
        // doubles as the ready vector.
        req_ready = w_grant;
        if (w_grant_valid) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_idx == IDX_W'(i)) begin
              a_d  = req_a[i*WIDTH +: WIDTH];
              b_d  = req_b[i*WIDTH +: WIDTH];
              op_d = req_op[i*3 +: 3];
            end
          end
          grant_idx_d = w_grant_idx;
`ifndef ALU_ARB_FIXED_PRIO_EN
          rr_ptr_d    = (w_grant_idx == C_LAST_IDX) ? '0
                                                    : w_grant_idx + IDX_W'(1);
`endif
          state_d     = ISSUE;
        end
      end

      ISSUE: begin
        alu_src_a = a_q;
        alu_src_b = b_q;
        alu_ctrl  = op_q;
        result_d  = alu_result;
        eq_d      = alu_eq;
        state_d   = RESP;
      end

      RESP: begin
        // Only the granted requester's rsp_ready completes the response.
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant_idx_q == IDX_W'(i)) begin
            rsp_valid[i] = 1'b1;
            w_rsp_ack    = rsp_ready[i];
          end
        end
        if (w_rsp_ack) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_idx_q <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      result_q    <= '0;
      eq_q        <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      result_q    <= result_d;
      eq_q        <= eq_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  assign rsp_result = result_q;
  assign rsp_eq     = eq_q;

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single execute-stage ALU (ADD/SUB/AND/XOR, 3-bit op code, EQ flag) between NUM_REQ requesters, e.g. the execute stage and the cache/address-calculation unit.
- Each requester uses a valid/ready handshake with registered operands. The block issues one op per grant and returns a registered result/EQ over a valid/ready response channel.
- Sits between the requesters and the combinational ALU; the ALU itself is unchanged.

Parameters:
- WIDTH, 32, operand/result width.
- NUM_REQ, 2, number of requesters (2..8).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester request accepted (one-hot or zero).
- req_a  input  NUM_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  operand B, same packing.
- req_op  input  NUM_REQ*3  ALU op code, requester i at [i*3 +: 3].
- rsp_valid  output  NUM_REQ  result valid for requester i (one-hot or zero).
- rsp_ready  input  NUM_REQ  requester i takes the result.
- rsp_result  output  WIDTH  result (shared bus, qualified by rsp_valid).
- rsp_eq  output  1  EQ flag of the op (shared, qualified by rsp_valid).
- alu_src_a  output  WIDTH  to ALU SrcAE.
- alu_src_b  output  WIDTH  to ALU SrcBE.
- alu_ctrl  output  3  to ALU ALUcontrolE.
- alu_result  input  WIDTH  from ALU ALUResult.
- alu_eq  input  1  from ALU EQ.

Behaviour:
- States: IDLE, ISSUE, RESP.
- Reset (sync, rst=1 at posedge):
  - state=IDLE, rr_ptr=0, grant_idx=0.
  - Operand/op/result/eq registers = 0.
  - rsp_valid=0, req_ready=0.
  - An in-flight op is dropped silently; rsp_valid does not assert for it.
- IDLE:
  - req_ready is combinational: req_ready[i]=1 only for the granted i, only in IDLE, and only if req_valid[i]=1.
  - Grant is round-robin: the first valid index at or after rr_ptr, wrapping NUM_REQ-1 to 0.
  - On accept: capture a/b/op/grant_idx; set rr_ptr=(grant_idx+1) mod NUM_REQ; go to ISSUE.
  - No valid requests: stay in IDLE; rr_ptr is unchanged.
- ISSUE (exactly 1 cycle):
  - alu_src_a/alu_src_b/alu_ctrl driven from the captured registers.
  - alu_result/alu_eq registered at the end of the cycle; go to RESP.
- RESP:
  - rsp_valid[grant_idx]=1; rsp_result/rsp_eq hold the registered values.
  - Hold until rsp_ready[grant_idx]=1, then return to IDLE.
  - rsp_ready on other indices is ignored.
- ALU outputs outside ISSUE: alu_src_a=0, alu_src_b=0, alu_ctrl=3'b000.
- Latency: accept in cycle N, rsp_valid in cycle N+2. Back-to-back throughput is 1 op per 3 cycles (rsp_ready tied high).
- Requests are sampled only in IDLE. A request presented during ISSUE/RESP waits; no accept overlaps RESP even if rsp_ready and req_valid are high in the same cycle.
- Requester rule: req_valid, once high, holds with stable a/b/op until req_ready. The arbiter does not check this.
- Op codes 011/101/110/111 pass through unchecked; the ALU returns result 0 and EQ 0, and these are returned normally.
- Widths: no extension or truncation; result is modulo 2^WIDTH, as produced by the ALU.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr_ptr is neither implemented nor updated.
- Undefined (default): round-robin as described above.

Decomposition:
- Package alu_arb_pkg:
  - State enum typedef {IDLE, ISSUE, RESP}.
  - Op localparams ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_XOR=3'b100.
- Sub-module rr_arbiter (NUM_REQ):
  - Inputs: request vector, rr_ptr.
  - Outputs: one-hot grant and binary index.
  - Holds the ALU_ARB_FIXED_PRIO_EN switch.

Test Plan:
- Single op: req0 a=5, b=3, op=000 → req_ready[0] in cycle 0; alu_ctrl=000 in cycle 1; rsp_valid[0] in cycle 2 with result=8, eq=0.
- SUB with equal operands: a=b=0x1234 → result=0, eq=1. Wrap-around: a=0, b=1, op=001 → result=0xFFFFFFFF.
- Contention: req0 and req1 both continuously valid, rsp_ready=11 → grants alternate 0,1,0,1 (with the macro defined: 0,0,0,0). Each response goes to the correct rsp_valid bit.
- Backpressure: rsp_ready[1]=0 for 4 cycles → rsp_valid[1] and the result are held stable; req0 valid during this window is not accepted until the cycle after the handshake.
- Reset mid-op: assert rst in the ISSUE cycle → next cycle IDLE, rsp_valid=0, no response for the dropped op; the next grant starts from index 0.
- Illegal op 3'b111: a=7, b=7 → rsp_result=0, rsp_eq=0; the arbiter continues normally.
